vproc_mem_responder: RTL
========================

# vproc_mem_responder

Single-port memory responder that implements the target side of the vector-processor memory request protocol (req/gnt/rvalid) driven by the data cache's line fill/spill port. It accepts word-wide read and write requests, stores data in an internal word array, and returns one response per granted request after a fixed pipeline latency. It is used as the backing store behind the cache in simulation and FPGA builds, with bounded outstanding requests and address-range error signalling.

## Interface
- ADDR_BIT_W, 16, byte address width
- MEM_BYTE_W, 4, data word width in bytes (power of two)
- MEM_DEPTH, 1024, number of words in the array (power of two, MEM_DEPTH*MEM_BYTE_W <= 2**ADDR_BIT_W)
- LATENCY, 2, cycles from grant to rvalid (>= 1)
- MAX_OUTSTANDING, 2, granted-but-unanswered request limit (1..LATENCY)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- mem_req_i  in  1  request valid
- mem_addr_i  in  ADDR_BIT_W  byte address
- mem_we_i  in  1  1 = write, 0 = read
- mem_wdata_i  in  MEM_BYTE_W*8  write data (full word, no byte enables)
- mem_gnt_o  out  1  request accepted this cycle
- mem_rvalid_o  out  1  response valid
- mem_rdata_o  out  MEM_BYTE_W*8  read data
- mem_err_o  out  1  response error, qualified by mem_rvalid_o

## Operation
- Grant: mem_gnt_o = mem_req_i & (outstanding < MAX_OUTSTANDING) & ~stall; combinational, no dependency on address/we. Request fields sampled only in granted cycle.
- Address decode: word index = mem_addr_i[log2(MEM_BYTE_W) +: log2(MEM_DEPTH)]. Error if mem_addr_i >= MEM_DEPTH*MEM_BYTE_W or low log2(MEM_BYTE_W) bits nonzero.
- Granted write, no error: array[index] <= mem_wdata_i at end of grant cycle. Response rdata = 0, err = 0.
- Granted write with error: array unchanged; response err = 1, rdata = 0.
- Granted read, no error: array read at grant edge; response rdata = array[index], err = 0.
- Granted read with error: rdata = 0, err = 1.
- Every granted request, read or write, yields exactly one response, in grant order.
- Response pipeline: LATENCY-stage shift register {valid, err, rdata}; stage 0 loaded at grant edge, output from last stage.
- Outstanding counter (width log2(MAX_OUTSTANDING)+1): +1 on grant, -1 on mem_rvalid_o, unchanged when both in same cycle. Never exceeds MAX_OUTSTANDING, never underflows.
- Array contents are not reset; uninitialised words read as X in simulation.

## Timing
- Reset values: mem_gnt_o 0 (counter 0 but reset forces gnt low while rst_i high), mem_rvalid_o 0, mem_rdata_o 0, mem_err_o 0, outstanding 0, all pipeline valid bits 0.
- Grant in cycle N -> mem_rvalid_o high in cycle N+LATENCY exactly; no rvalid backpressure.
- Back-to-back: with MAX_OUTSTANDING = LATENCY, one grant per cycle sustained; with smaller limit, gnt drops when counter full and reasserts in the cycle rvalid frees a slot (same-cycle grant allowed).
- Write at N then read same address at N+1: read returns new data.
- Reset mid-operation: in-flight responses discarded immediately, no rvalid after release; first grant possible in first cycle after rst_i deasserts.
- mem_req_i low: no state change besides pipeline advance.

## Configuration
- VPROC_MEM_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 on reset, advances every cycle; stall = (lfsr[1:0] == 2'b00), suppressing grant ~25% of cycles to stress cache fill/spill counters. Response latency unchanged.
- Not defined: stall = 0, no LFSR logic; grant limited only by outstanding count.

## Test plan
- Write 0xDEADBEEF to 0x0040, read 0x0040 next cycle -> gnt both cycles, rvalid at grant+2 for each, second rdata = 0xDEADBEEF, err 0.
- Four consecutive line-fill reads 0x0100..0x010C with req held -> 4 grants in 4 cycles, 4 rvalids in order with preloaded words.
- MAX_OUTSTANDING=1, LATENCY=2, req held -> gnt pattern 1,0,1,0; never two outstanding.
- Read 0x1000 (out of range, MEM_DEPTH=1024) and read 0x0042 (misaligned) -> rvalid with err=1, rdata=0; write to 0x1000 leaves array unchanged.
- Assert rst_i one cycle after two grants -> no rvalid after reset release, outputs 0, next request granted immediately.
- With VPROC_MEM_STALL_EN, 1000 random requests -> each granted request receives exactly one response after exactly LATENCY cycles, data matches scoreboard.

Source files
------------

// File: rtl/vproc_mem_responder_if.sv
// Memory request bus (req/gnt/rvalid) between the data cache fill/spill port
// and its backing store: master = cache side, slave = memory side.
interface vproc_mem_responder_if #(
    parameter int ADDR_BIT_W = 16,
    parameter int MEM_BYTE_W = 4
);
    logic                    req;
    logic [ADDR_BIT_W-1:0]   addr;
    logic                    we;
    logic [MEM_BYTE_W*8-1:0] wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [MEM_BYTE_W*8-1:0] rdata;
    logic                    err;

    modport master (output req, addr, we, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, we, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/vproc_mem_responder.sv
// Word-wide memory responder with fixed response latency and bounded outstanding requests.
// Define VPROC_MEM_STALL_EN to add LFSR-driven random grant stalls.
module vproc_mem_responder #(
    parameter int ADDR_BIT_W      = 16,
    parameter int MEM_BYTE_W      = 4,
    parameter int MEM_DEPTH       = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    vproc_mem_responder_if.slave  mem
);
    localparam int DATA_W = MEM_BYTE_W * 8;
    localparam int OFF_W  = $clog2(MEM_BYTE_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [ADDR_BIT_W:0]   MEM_BYTES = (ADDR_BIT_W + 1)'(MEM_DEPTH * MEM_BYTE_W);
    localparam logic [ADDR_BIT_W-1:0] OFF_MASK  = ADDR_BIT_W'(MEM_BYTE_W - 1);
    localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_OUTSTANDING);

    function automatic logic addr_err(input logic [ADDR_BIT_W-1:0] a);
        return ({1'b0, a} >= MEM_BYTES) || ((a & OFF_MASK) != '0);
    endfunction

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              req_err;
    logic              stall;
    logic              gnt;
    logic [CNT_W-1:0]  cnt_q;

    logic [LATENCY-1:0] vld_p;
    logic [LATENCY-1:0] err_p;
    logic [DATA_W-1:0]  rdata_p [LATENCY];

    assign idx     = mem.addr[OFF_W +: IDX_W];
    assign req_err = addr_err(mem.addr);

`ifdef VPROC_MEM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // A response leaving this cycle frees its slot in time for a same-cycle grant,
    // which lets MAX_OUTSTANDING == LATENCY sustain one grant per cycle.
    assign gnt = mem.req & ~rst_i & ~stall & ((cnt_q < MAX_CNT) | vld_p[LATENCY-1]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            case ({gnt, vld_p[LATENCY-1]})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (gnt && mem.we && !req_err) begin
            mem_q[idx] <= mem.wdata;
        end
    end

    // Stage 0: captured at the grant edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p <= '0;
            err_p <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                rdata_p[i] <= '0;
            end
        end else begin
            vld_p[0]   <= gnt;
            err_p[0]   <= gnt & req_err;
            rdata_p[0] <= (gnt && !mem.we && !req_err) ? mem_q[idx] : '0;
            // Stages 1..LATENCY-1: plain shift toward the output
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i]   <= vld_p[i-1];
                err_p[i]   <= err_p[i-1];
                rdata_p[i] <= rdata_p[i-1];
            end
        end
    end

    assign mem.gnt    = gnt;
    assign mem.rvalid = vld_p[LATENCY-1];
    assign mem.err    = err_p[LATENCY-1];
    assign mem.rdata  = rdata_p[LATENCY-1];

endmodule
